iq_mixer: RTL and testbench

Quadrature carrier mixer that sits directly upstream of the SSB phasing combiner. It takes one 24-bit audio sample per LRCLK frame and multiplies it by cosine and sine of a numerically controlled carrier phase. The two 24-bit products are delivered as the combiner's `i` and `q` channels. A quarter-wave sine ROM and one shared multiplier are sequenced by a small FSM, so each sample takes a few clock cycles, and the frame rate is far lower than `clk`.

---
 rtl/iq_mixer.sv | 233 +++++++++++++++++++++++
 tb/tb_iq_mixer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/iq_mixer.sv
// iq_mixer: quadrature carrier mixer ahead of the SSB phasing combiner.
// Each accepted audio sample is multiplied by cos and sin of an NCO phase,
// using a quarter-wave sine ROM and one shared multiplier sequenced by an FSM.
// Optional feature: define IQ_MIXER_PHASE_DITHER_EN to add LFSR phase dither
// below the ROM address bits before the quadrant decode.
module iq_mixer #(
    parameter int PHASE_W = 32,
    parameter int LUT_AW  = 8,
    parameter int DATA_W  = 24,
    parameter int COEF_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               next_lrclk_fall,
    input  logic               ena,
    input  logic               phase_clr,
    input  logic [PHASE_W-1:0] phase_inc,
    input  logic [DATA_W-1:0]  x_in,
    output logic [DATA_W-1:0]  i_out,
    output logic [DATA_W-1:0]  q_out,
    output logic               o_valid,
    output logic               busy,
    output logic               overrun
);

    localparam int ROM_N  = 1 << LUT_AW;
    localparam int TOP_W  = LUT_AW + 2;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam logic signed [PROD_W-1:0] ROUND_BIAS = PROD_W'(1) << (COEF_W - 2);

    typedef enum logic [2:0] {IDLE, ADDR, READ, MUL_I, MUL_Q} MixState;

    MixState                    r_state;
    MixState                    w_nextState;
    logic [PHASE_W-1:0]         r_acc;
    logic [PHASE_W-1:0]         w_accBase;
    logic [TOP_W-1:0]           w_phTop;
    logic [TOP_W-1:0]           r_phTop;
    logic [TOP_W-1:0]           w_cosTop;
    logic signed [DATA_W-1:0]   r_x;
    logic [LUT_AW-1:0]          r_sinAddr;
    logic [LUT_AW-1:0]          r_cosAddr;
    logic                       r_sinNeg;
    logic                       r_cosNeg;
    logic [COEF_W-1:0]          r_sinRom;
    logic [COEF_W-1:0]          r_cosRom;
    logic [COEF_W-1:0]          w_coefMag;
    logic                       w_coefNeg;
    logic signed [COEF_W-1:0]   w_coef;
    logic signed [PROD_W-1:0]   w_prod;
    logic signed [PROD_W-1:0]   r_prodI;
    logic signed [PROD_W-1:0]   r_prodQ;
    logic [DATA_W-1:0]          w_iRes;
    logic [DATA_W-1:0]          w_qRes;
    logic                       r_outPend;
    logic [DATA_W-1:0]          r_iOut;
    logic [DATA_W-1:0]          r_qOut;
    logic                       r_valid;
    logic                       r_overrun;
    logic                       w_strobe;
    logic                       w_busy;
    logic                       w_accept;
    logic [COEF_W-1:0]          w_rom [ROM_N];

    // Quarter-wave table entry k = round(A*sin(pi/2*(k+0.5)/N)), computed at
    // elaboration with a Q30 Taylor series so no real arithmetic is needed.
    function automatic logic [COEF_W-1:0] sinEntry(input int k);
        longint halfPi;
        longint x;
        longint x2;
        longint term;
        longint acc;
        longint amp;
        halfPi = 64'sd1686629713;
        x      = ((2 * longint'(k) + 1) * halfPi) >>> (LUT_AW + 1);
        x2     = (x * x) >>> 30;
        term   = x;
        acc    = x;
        for (int n = 1; n <= 8; n++) begin
            term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
            acc  = acc + term;
        end
        amp = (longint'(1) <<< (COEF_W - 1)) - 1;
        return COEF_W'((acc * amp + (longint'(1) <<< 29)) >>> 30);
    endfunction

    for (genvar k = 0; k < ROM_N; k++) begin : g_rom
        localparam logic [COEF_W-1:0] ENTRY = sinEntry(k);
        assign w_rom[k] = ENTRY;
    end

    // The output stage runs one cycle after MUL_Q, so busy covers it too;
    // this keeps strobes in the final cycle of a sample from being accepted.
    assign w_strobe  = next_lrclk_fall & ena;
    assign w_busy    = (r_state != IDLE) | r_outPend;
    assign w_accept  = w_strobe & ~w_busy;
    assign w_accBase = phase_clr ? '0 : r_acc;
    assign w_cosTop  = r_phTop + TOP_W'(1 << (TOP_W - 2));

`ifdef IQ_MIXER_PHASE_DITHER_EN
    localparam int DITHER_W = PHASE_W - 2 - LUT_AW;
    localparam logic [PHASE_W-1:0] DITHER_MASK = (PHASE_W'(1) << DITHER_W) - PHASE_W'(1);
    logic [15:0]        r_lfsr;
    logic [PHASE_W-1:0] w_dither;

    assign w_dither = PHASE_W'(r_lfsr) & DITHER_MASK;

    // Dither source: Fibonacci LFSR stepped once per accepted sample
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= 16'hACE1;
        end else if (w_accept) begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    assign w_phTop = TOP_W'((w_accBase + w_dither) >> (PHASE_W - TOP_W));
`else
    assign w_phTop = w_accBase[PHASE_W-1 -: TOP_W];
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: fixed walk through the datapath after each accept
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_nextState = ADDR;
            ADDR:    w_nextState = READ;
            READ:    w_nextState = MUL_I;
            MUL_I:   w_nextState = MUL_Q;
            MUL_Q:   w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Phase accumulator, sample capture and dropped-strobe flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_phTop   <= '0;
            r_x       <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_strobe & w_busy;
            if (w_accept) begin
                r_acc   <= w_accBase + phase_inc;
                r_phTop <= w_phTop;
                r_x     <= x_in;
            end else if (phase_clr) begin
                r_acc <= '0;
            end
        end
    end

    // Quadrant decode for both carriers, then the two-port ROM read
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sinAddr <= '0;
            r_cosAddr <= '0;
            r_sinNeg  <= 1'b0;
            r_cosNeg  <= 1'b0;
            r_sinRom  <= '0;
            r_cosRom  <= '0;
        end else begin
            if (r_state == ADDR) begin
                r_sinAddr <= r_phTop[TOP_W-2] ? ~r_phTop[LUT_AW-1:0] : r_phTop[LUT_AW-1:0];
                r_sinNeg  <= r_phTop[TOP_W-1];
                r_cosAddr <= w_cosTop[TOP_W-2] ? ~w_cosTop[LUT_AW-1:0] : w_cosTop[LUT_AW-1:0];
                r_cosNeg  <= w_cosTop[TOP_W-1];
            end
            if (r_state == READ) begin
                r_sinRom <= w_rom[r_sinAddr];
                r_cosRom <= w_rom[r_cosAddr];
            end
        end
    end

    // Shared multiplier: cosine coefficient in MUL_I, sine in MUL_Q
    always_comb begin
        w_coefMag = r_sinRom;
        w_coefNeg = r_sinNeg;
        if (r_state == MUL_I) begin
            w_coefMag = r_cosRom;
            w_coefNeg = r_cosNeg;
        end
        w_coef = w_coefNeg ? -$signed(w_coefMag) : $signed(w_coefMag);
        w_prod = PROD_W'(r_x) * PROD_W'(w_coef);
    end

    assign w_iRes = DATA_W'((r_prodI + ROUND_BIAS) >>> (COEF_W - 1));
    assign w_qRes = DATA_W'((r_prodQ + ROUND_BIAS) >>> (COEF_W - 1));

    // Product capture and simultaneous rounded update of both outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prodI   <= '0;
            r_prodQ   <= '0;
            r_outPend <= 1'b0;
            r_iOut    <= '0;
            r_qOut    <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_valid   <= r_outPend;
            r_outPend <= 1'b0;
            if (r_state == MUL_I) begin
                r_prodI <= w_prod;
            end
            if (r_state == MUL_Q) begin
                r_prodQ   <= w_prod;
                r_outPend <= 1'b1;
            end
            if (r_outPend) begin
                r_iOut <= w_iRes;
                r_qOut <= w_qRes;
            end
        end
    end

    assign i_out   = r_iOut;
    assign q_out   = r_qOut;
    assign o_valid = r_valid;
    assign busy    = w_busy;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_iq_mixer.sv
// Testbench for iq_mixer: directed steps with a scoreboard of expected I/Q pairs.
`timescale 1ns/1ps
module tb_iq_mixer;

    logic        clk = 1'b0;
    logic        rst;
    logic        next_lrclk_fall;
    logic        ena;
    logic        phase_clr;
    logic [31:0] phase_inc;
    logic [23:0] x_in;
    logic [23:0] i_out;
    logic [23:0] q_out;
    logic        o_valid;
    logic        busy;
    logic        overrun;

    int          checkCount = 0;
    int          errorCount = 0;
    int          validCount = 0;
    logic [47:0] expQueue [$];

    always #5 clk = ~clk;

    iq_mixer dut (
        .clk             (clk),
        .rst             (rst),
        .next_lrclk_fall (next_lrclk_fall),
        .ena             (ena),
        .phase_clr       (phase_clr),
        .phase_inc       (phase_inc),
        .x_in            (x_in),
        .i_out           (i_out),
        .q_out           (q_out),
        .o_valid         (o_valid),
        .busy            (busy),
        .overrun         (overrun)
    );

    // Single comparison point: counts every check and every failure
    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference: (x*coef + 2^14) >>> 15, truncated to 24 bits
    function automatic logic [23:0] mixRef(input int x, input int coef);
        longint p;
        p = longint'(x) * longint'(coef) + 64'sd16384;
        p = p >>> 15;
        return p[23:0];
    endfunction

    // Signed ROM coefficient seen at phase = quad * 2^30 (table ends are 101 and 32767)
    function automatic int sinCoef(input int quad);
        case (quad & 3)
            0:       return 101;
            1:       return 32767;
            2:       return -101;
            default: return -32767;
        endcase
    endfunction

    function automatic int cosCoef(input int quad);
        return sinCoef(quad + 1);
    endfunction

    // Scoreboard: every o_valid pops one expected pair
    always @(negedge clk) begin
        if (o_valid === 1'b1) begin
            logic [47:0] exp;
            validCount++;
            checkOutput("pending_at_valid", longint'(expQueue.size() > 0), 1);
            if (expQueue.size() > 0) begin
                exp = expQueue.pop_front();
                checkOutput("i_out", longint'(i_out), longint'(exp[47:24]));
                checkOutput("q_out", longint'(q_out), longint'(exp[23:0]));
            end
        end
    end

    // Drive one strobe for one cycle; returns at the negedge after the sampling edge
    task automatic applyStimulus(input int x, input logic [31:0] inc, input logic clr, input logic en);
        @(negedge clk);
        x_in            = 24'(x);
        phase_inc       = inc;
        phase_clr       = clr;
        ena             = en;
        next_lrclk_fall = 1'b1;
        @(negedge clk);
        next_lrclk_fall = 1'b0;
        phase_clr       = 1'b0;
    endtask

    // Accepted sample: push expectation, then check latency, pulse width and hold
    task automatic runSample(input int x, input logic [31:0] inc, input logic clr, input int quad);
        logic [23:0] expI;
        logic [23:0] expQ;
        int          lat;
        int          pulses;
        lat    = 0;
        pulses = 0;
        expI   = mixRef(x, cosCoef(quad));
        expQ   = mixRef(x, sinCoef(quad));
        expQueue.push_back({expI, expQ});
        applyStimulus(x, inc, clr, 1'b1);
        checkOutput("busy_after_accept", longint'(busy), 1);
        for (int n = 1; n <= 10; n++) begin
            if (o_valid === 1'b1) begin
                pulses++;
                if (lat == 0) lat = n;
            end
            if (n < 10) @(negedge clk);
        end
        checkOutput("valid_latency", longint'(lat), 6);
        checkOutput("valid_pulse_count", longint'(pulses), 1);
        checkOutput("busy_after_done", longint'(busy), 0);
        checkOutput("i_out_hold", longint'(i_out), longint'(expI));
        checkOutput("q_out_hold", longint'(q_out), longint'(expQ));
    endtask

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence
    initial begin
        int base;
        rst             = 1'b1;
        ena             = 1'b1;
        next_lrclk_fall = 1'b0;
        phase_clr       = 1'b0;
        phase_inc       = '0;
        x_in            = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_i_out", longint'(i_out), 0);
        checkOutput("reset_q_out", longint'(q_out), 0);
        checkOutput("reset_o_valid", longint'(o_valid), 0);
        checkOutput("reset_busy", longint'(busy), 0);
        checkOutput("reset_overrun", longint'(overrun), 0);
        rst = 1'b0;

        $display("[TB] phase 0");
        runSample(32'h0040_0000, 32'h0, 1'b1, 0);
        checkOutput("phase0_i", longint'(i_out), longint'(24'h3FFF80));
        checkOutput("phase0_q", longint'(q_out), longint'(24'h003280));

        $display("[TB] phase 0x80000000");
        runSample(32'h0040_0000, 32'h8000_0000, 1'b1, 0);
        runSample(32'h0040_0000, 32'h0, 1'b0, 2);
        checkOutput("phase180_i", longint'(i_out), longint'(24'hC00080));
        checkOutput("phase180_q", longint'(q_out), longint'(24'hFFCD80));

        $display("[TB] accumulation over four quadrants");
        runSample(32'h0040_0000, 32'h4000_0000, 1'b1, 0);
        runSample(32'h0040_0000, 32'h4000_0000, 1'b0, 1);
        runSample(32'h0040_0000, 32'h4000_0000, 1'b0, 2);
        runSample(32'h0040_0000, 32'h4000_0000, 1'b0, 3);
        runSample(32'h0040_0000, 32'h0, 1'b0, 0);

        $display("[TB] overrun");
        base = validCount;
        expQueue.push_back({mixRef(32'h0040_0000, cosCoef(0)), mixRef(32'h0040_0000, sinCoef(0))});
        @(negedge clk);
        x_in = 24'h400000; phase_inc = 32'h4000_0000; next_lrclk_fall = 1'b1;
        @(negedge clk);
        next_lrclk_fall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        next_lrclk_fall = 1'b1;
        @(negedge clk);
        next_lrclk_fall = 1'b0;
        checkOutput("overrun_pulse", longint'(overrun), 1);
        @(negedge clk);
        checkOutput("overrun_width", longint'(overrun), 0);
        @(negedge clk);
        checkOutput("valid_at_e5", longint'(o_valid), 1);
        expQueue.push_back({mixRef(32'h0040_0000, cosCoef(1)), mixRef(32'h0040_0000, sinCoef(1))});
        phase_inc = 32'h0; next_lrclk_fall = 1'b1;
        @(negedge clk);
        next_lrclk_fall = 1'b0;
        checkOutput("accept_at_e6", longint'(busy), 1);
        checkOutput("no_overrun_at_e6", longint'(overrun), 0);
        repeat (9) @(negedge clk);
        checkOutput("overrun_valid_count", longint'(validCount - base), 2);

        $display("[TB] gating");
        base = validCount;
        applyStimulus(32'h0040_0000, 32'h1234_5678, 1'b0, 1'b0);
        checkOutput("gated_busy", longint'(busy), 0);
        checkOutput("gated_overrun", longint'(overrun), 0);
        repeat (8) @(negedge clk);
        checkOutput("gated_no_valid", longint'(validCount - base), 0);
        checkOutput("gated_i_hold", longint'(i_out), longint'(mixRef(32'h0040_0000, cosCoef(1))));
        runSample(32'h0040_0000, 32'h0, 1'b0, 1);
        runSample(-32'sd4194304, 32'h0, 1'b1, 0);
        checkOutput("neg_x_i", longint'(i_out), longint'(24'hC00080));
        runSample(-32'sd8388608, 32'h0, 1'b1, 0);

        $display("[TB] reset mid-sample");
        base = validCount;
        applyStimulus(32'h0040_0000, 32'h4000_0000, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("midreset_i_out", longint'(i_out), 0);
        checkOutput("midreset_q_out", longint'(q_out), 0);
        checkOutput("midreset_busy", longint'(busy), 0);
        checkOutput("midreset_o_valid", longint'(o_valid), 0);
        repeat (8) @(negedge clk);
        checkOutput("midreset_no_valid", longint'(validCount - base), 0);
        runSample(32'h0040_0000, 32'h0, 1'b0, 0);

        checkOutput("scoreboard_drained", longint'(expQueue.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
